// File: rtl/fifo_pkg.sv
// Shared types for the FIFO stream reader.
// word_t is the FIFO word; occ_t counts buffered words (0..2).
package fifo_pkg;

   localparam int WIDTH     = 8;
   localparam int BUF_DEPTH = 2;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [1:0]       occ_t;

endpackage

// File: rtl/fifo_stream_reader_buf2.sv
// stream_buf2: 2-entry ring buffer with registered head word.
// Pointers are 1 bit wide and wrap naturally.
module stream_buf2 #(
   parameter int WIDTH = fifo_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       occ,
   output logic             valid,
   output logic [WIDTH-1:0] head
);

   import fifo_pkg::*;

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wptr_q;
   logic             wptr_d;
   logic             rptr_q;
   logic             rptr_d;
   occ_t             occ_q;
   occ_t             occ_d;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q + occ_t'(push) - occ_t'(pop);
      if (push) begin
         mem_d[wptr_q] = push_data;
         wptr_d        = ~wptr_q;
      end
      if (pop) begin
         rptr_d = ~rptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         occ_q    <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
      end
   end

   // Head word comes straight from storage, never from push_data.
   assign head  = mem_q[rptr_q];
   assign valid = (occ_q != 2'd0);
   assign occ   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO read port into a valid/ready stream via a 2-entry buffer.
// Define FSR_STATS_EN to add the word_cnt delivered-word counter.
module fifo_stream_reader #(
   parameter int WIDTH     = fifo_pkg::WIDTH,
   parameter int BUF_DEPTH = fifo_pkg::BUF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
`ifdef FSR_STATS_EN
   ,
   output logic [15:0]      word_cnt
`endif
);

   import fifo_pkg::*;

   logic       pending_q;
   logic       pending_d;
   logic       pop;
   occ_t       occ;
   logic [2:0] credit;

   assign pop = m_valid && m_ready;

   // Words buffered plus in flight, after this cycle's pop.
   always_comb begin
      credit     = {1'b0, occ} + {2'b0, pending_q} - {2'b0, pop};
      fifo_rd_en = !rst && !fifo_empty && (credit < 3'(BUF_DEPTH));
      pending_d  = fifo_rd_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end

   stream_buf2 #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (pending_q),
      .push_data (fifo_data),
      .pop       (pop),
      .occ       (occ),
      .valid     (m_valid),
      .head      (m_data)
   );

`ifdef FSR_STATS_EN
   logic [15:0] word_cnt_q;
   logic [15:0] word_cnt_d;

   always_comb begin
      word_cnt_d = word_cnt_q + 16'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt_q <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
      end
   end

   assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + random bench for fifo_stream_reader against a queue model.
// Define FSR_STATS_EN to also check word_cnt.
module tb_fifo_stream_reader;

   import fifo_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  fifo_rd_en;
   word_t fifo_data;
   logic  fifo_empty;
   logic  m_valid;
   logic  m_ready;
   word_t m_data;
`ifdef FSR_STATS_EN
   logic [15:0] word_cnt;
`endif

   always #5 clk = ~clk;

   fifo_stream_reader #(
      .WIDTH     (WIDTH),
      .BUF_DEPTH (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
`ifdef FSR_STATS_EN
      ,
      .word_cnt   (word_cnt)
`endif
   );

   typedef struct {
      word_t d;
      int    t;
   } ent_t;

   word_t       fq[$];
   ent_t        oq[$];
   int          cyc;
   int          n_assert;
   int          n_fail;
   int          n_deliv;
   int          n_fed;
   int          n_rd;
   int          base;
   int unsigned cnt_exp;
   bit          chk_zero;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic feed(input word_t v);
      fq.push_back(v);
      n_fed++;
   endtask

   // One clock: drive, check against the model, advance the model.
   task automatic cycle(input logic rdy);
      logic ev;
      logic pop;
      logic er;
      logic rd_act;
      ent_t e;
      m_ready    = rdy;
      fifo_empty = (fq.size() == 0);
      #1;
      ev  = (oq.size() > 0) && (cyc >= oq[0].t + 2);
      pop = ev && rdy;
      er  = !rst && !fifo_empty && ((oq.size() - int'(pop)) < 2);
      chk("m_valid", m_valid, ev);
      chk("fifo_rd_en", fifo_rd_en, er);
      chk("rd_while_empty", fifo_rd_en && fifo_empty, 0);
      if (ev) chk("m_data", m_data, oq[0].d);
      if (chk_zero) chk("m_data_rst", m_data, 0);
`ifdef FSR_STATS_EN
      chk("word_cnt", word_cnt, cnt_exp);
`endif
      rd_act = fifo_rd_en;
      @(posedge clk);
      #1;
      if (rst) begin
         oq.delete();
         fq.delete();
         cnt_exp = 0;
         n_deliv = 0;
         n_fed   = 0;
      end else begin
         if (pop) begin
            void'(oq.pop_front());
            n_deliv++;
            cnt_exp = (cnt_exp + 1) & 32'hffff;
         end
         if (rd_act && fq.size() > 0) begin
            e.d       = fq.pop_front();
            e.t       = cyc;
            fifo_data = e.d;
            oq.push_back(e);
            n_rd++;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      m_ready    = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      cyc        = 0;
      n_assert   = 0;
      n_fail     = 0;
      n_deliv    = 0;
      n_fed      = 0;
      n_rd       = 0;
      cnt_exp    = 0;
      chk_zero   = 1'b0;

      // Reset with the FIFO holding data
      for (int i = 1; i <= 8; i++) feed(word_t'(i));
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk_zero = 1'b1;
      cycle(1'b1);
      rst = 1'b0;
      cycle(1'b1);
      chk_zero = 1'b0;

      // Streaming at full rate
      for (int i = 1; i <= 8; i++) feed(word_t'(i));
      base = n_rd;
      repeat (14) cycle(1'b1);
      chk("stream_reads", n_rd - base, 8);
      chk("stream_deliv", n_deliv, 8);

      // Backpressure: buffer fills, head holds
      for (int i = 1; i <= 8; i++) feed(word_t'(i));
      base = n_rd;
      repeat (6) cycle(1'b0);
      chk("bp_reads", n_rd - base, 2);
      chk("bp_valid", m_valid, 1);
      chk("bp_head", m_data, 1);
      repeat (14) cycle(1'b1);
      chk("bp_deliv", n_deliv, 16);

      // Alternating ready
      for (int i = 1; i <= 8; i++) feed(word_t'(i));
      for (int i = 0; i < 30; i++) cycle(i % 2 == 0);
      chk("toggle_deliv", n_deliv, 24);

      // Mid-stream reset after 3 words
      for (int i = 1; i <= 8; i++) feed(word_t'(i));
      base = n_deliv;
      for (int i = 0; i < 20 && n_deliv - base < 3; i++) cycle(1'b1);
      chk("mid_three", n_deliv - base, 3);
`ifdef FSR_STATS_EN
      chk("cnt_before_rst", word_cnt, cnt_exp);
`endif
      rst = 1'b1;
      cycle(1'b1);
      rst = 1'b0;
      repeat (4) cycle(1'b1);
      chk("post_rst_deliv", n_deliv, 0);
`ifdef FSR_STATS_EN
      chk("cnt_after_rst", word_cnt, 0);
`endif

      // Random traffic and ready
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(2, 0) == 0) feed(word_t'($urandom));
         cycle($urandom_range(3, 0) != 0);
      end
      for (int i = 0; i < 40 && n_deliv != n_fed; i++) cycle(1'b1);
      chk("rand_drain", n_deliv, n_fed);
      cycle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
